mips_exec_decode: RTL and testbench

- Single-cycle MIPS decode-and-execute slice with registered outputs.
- Merges three functions: main control decode (opcode to datapath controls), ALU-control decode (ALUOp + funct to 4-bit ALU op), and the 32-bit ALU with zero flag.
- Sits between the register file and the data memory / PC-update logic of the MIPS32 core.

---
 rtl/mips_exec_decode.sv | 205 ++++++++++++++++++++
 tb/tb_mips_exec_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_decode.sv
// Single-cycle MIPS decode/execute slice: main control, ALU control and 32-bit ALU, all registered.
// Optional SLL/SRL support is enabled by defining MIPS_EXEC_SHIFT_EN.
module mips_exec_decode #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              reg_dst,
    output logic              branch,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              alu_src,
    output logic              reg_write,
    output logic              jump,
    output logic [1:0]        alu_op,
    output logic [3:0]        alu_ctrl,
    output logic              illegal
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnNor = 6'b100111;
`ifdef MIPS_EXEC_SHIFT_EN
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
`endif

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;
    localparam logic [3:0] AluNor = 4'b1100;
    localparam logic [3:0] AluBad = 4'b1111;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign shamt        = instr[10:6];
    assign unused_instr = ^{instr[25:11], shamt};

    logic       reg_dst_d, branch_d, mem_read_d, mem_to_reg_d;
    logic       mem_write_d, alu_src_d, reg_write_d, jump_d;
    logic [1:0] alu_op_d;
    logic       bad_op_d;

    always_comb begin
        reg_dst_d    = 1'b0;
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        jump_d       = 1'b0;
        alu_op_d     = 2'b00;
        bad_op_d     = 1'b0;
        case (opcode)
            OpRtype: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OpLw: begin
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
            end
            OpSw: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OpBeq: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
            end
            OpAddi: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            OpJ:     jump_d   = 1'b1;
            default: bad_op_d = 1'b1;
        endcase
    end

    logic [3:0] alu_ctrl_d;
    logic       bad_fn_d;

    always_comb begin
        alu_ctrl_d = AluAdd;
        bad_fn_d   = 1'b0;
        case (alu_op_d)
            2'b01: alu_ctrl_d = AluSub;
            2'b10: begin
                case (funct)
                    FnAdd: alu_ctrl_d = AluAdd;
                    FnSub: alu_ctrl_d = AluSub;
                    FnAnd: alu_ctrl_d = AluAnd;
                    FnOr:  alu_ctrl_d = AluOr;
                    FnSlt: alu_ctrl_d = AluSlt;
                    FnNor: alu_ctrl_d = AluNor;
`ifdef MIPS_EXEC_SHIFT_EN
                    FnSll: alu_ctrl_d = AluSll;
                    FnSrl: alu_ctrl_d = AluSrl;
`endif
                    default: begin
                        alu_ctrl_d = AluBad;
                        bad_fn_d   = 1'b1;
                    end
                endcase
            end
            // 2'b00 and the never-produced 2'b11 both select ADD
            default: alu_ctrl_d = AluAdd;
        endcase
    end

    logic [DATA_W-1:0] op_a, op_b, imm_ext;
    logic [DATA_W-1:0] result_d;
    logic              slt_d;

    assign imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign op_a    = rs_data;
    assign op_b    = alu_src_d ? imm_ext : rt_data;
    assign slt_d   = $signed(op_a) < $signed(op_b);

    always_comb begin
        result_d = '0;
        case (alu_ctrl_d)
            AluAdd: result_d = op_a + op_b;
            AluSub: result_d = op_a - op_b;
            AluAnd: result_d = op_a & op_b;
            AluOr:  result_d = op_a | op_b;
            AluSlt: result_d = {{(DATA_W-1){1'b0}}, slt_d};
            AluNor: result_d = ~(op_a | op_b);
`ifdef MIPS_EXEC_SHIFT_EN
            // Shifts act on rt only; rs is ignored
            AluSll: result_d = rt_data << shamt;
            AluSrl: result_d = rt_data >> shamt;
`else
            AluSll, AluSrl: result_d = '0;
`endif
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            reg_dst    <= 1'b0;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            jump       <= 1'b0;
            alu_op     <= 2'b00;
            alu_ctrl   <= 4'b0000;
            illegal    <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            result     <= result_d;
            zero       <= (result_d == '0);
            reg_dst    <= reg_dst_d;
            branch     <= branch_d;
            mem_read   <= mem_read_d;
            mem_to_reg <= mem_to_reg_d;
            mem_write  <= mem_write_d;
            alu_src    <= alu_src_d;
            reg_write  <= reg_write_d;
            jump       <= jump_d;
            alu_op     <= alu_op_d;
            alu_ctrl   <= alu_ctrl_d;
            illegal    <= bad_op_d | bad_fn_d;
        end
    end

endmodule

// File: tb/tb_mips_exec_decode.sv
// Directed, table-driven bench for mips_exec_decode, with hand-written reset sequences.
module tb_mips_exec_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr, rs_data, rt_data;
    logic        out_valid, zero, illegal;
    logic [31:0] result;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_exec_decode #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .jump       (jump),
        .alu_op     (alu_op),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal)
    );

    // ctl packing: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic        zero;
        logic [7:0]  ctl;
        logic [1:0]  aop;
        logic [3:0]  actl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [31:0] i, logic [31:0] a, logic [31:0] b,
                                logic [31:0] r, logic z, logic [7:0] c, logic [1:0] ao,
                                logic [3:0] ac, logic il);
        vec_t v;
        v.name = n; v.instr = i; v.rs = a; v.rt = b; v.res = r; v.zero = z;
        v.ctl = c; v.aop = ao; v.actl = ac; v.ill = il;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] i, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        in_valid = v; instr = i; rs_data = a; rt_data = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl_now();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump};
    endfunction

    task automatic check_all_zero(string n);
        check({n, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({n, ".result"}, result, 32'd0);
        check({n, ".zero"}, {31'd0, zero}, 32'd0);
        check({n, ".ctl"}, {24'd0, ctl_now()}, 32'd0);
        check({n, ".alu_op"}, {30'd0, alu_op}, 32'd0);
        check({n, ".alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
        check({n, ".illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        vecs.push_back(mk("add", 32'h0000_0020, 32'd7, 32'd5, 32'd12, 1'b0,
                          8'b1001_0000, 2'b10, 4'b0010, 1'b0));
        vecs.push_back(mk("add_wrap", 32'h0000_0020, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0,
                          8'b1001_0000, 2'b10, 4'b0010, 1'b0));
        vecs.push_back(mk("sub_eq", 32'h0000_0022, 32'h1234, 32'h1234, 32'd0, 1'b1,
                          8'b1001_0000, 2'b10, 4'b0110, 1'b0));
        vecs.push_back(mk("sub_wrap", 32'h0000_0022, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0,
                          8'b1001_0000, 2'b10, 4'b0110, 1'b0));
        vecs.push_back(mk("slt_neg", 32'h0000_002A, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0,
                          8'b1001_0000, 2'b10, 4'b0111, 1'b0));
        vecs.push_back(mk("slt_false", 32'h0000_002A, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1,
                          8'b1001_0000, 2'b10, 4'b0111, 1'b0));
        vecs.push_back(mk("slt_2neg", 32'h0000_002A, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 1'b0,
                          8'b1001_0000, 2'b10, 4'b0111, 1'b0));
        vecs.push_back(mk("nor", 32'h0000_0027, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0,
                          8'b1001_0000, 2'b10, 4'b1100, 1'b0));
        vecs.push_back(mk("and", 32'h0000_0024, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0,
                          1'b0, 8'b1001_0000, 2'b10, 4'b0000, 1'b0));
        vecs.push_back(mk("or", 32'h0000_0025, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF,
                          1'b0, 8'b1001_0000, 2'b10, 4'b0001, 1'b0));
        vecs.push_back(mk("lw", 32'h8C00_FFFC, 32'h100, 32'h5555, 32'h0000_00FC, 1'b0,
                          8'b0111_1000, 2'b00, 4'b0010, 1'b0));
        vecs.push_back(mk("sw", 32'hAC00_0008, 32'h10, 32'h7777, 32'h18, 1'b0,
                          8'b0100_0100, 2'b00, 4'b0010, 1'b0));
        vecs.push_back(mk("beq", 32'h1000_0004, 32'd9, 32'd9, 32'd0, 1'b1,
                          8'b0000_0010, 2'b01, 4'b0110, 1'b0));
        vecs.push_back(mk("addi_neg", 32'h2000_FFFF, 32'd1, 32'd99, 32'd0, 1'b1,
                          8'b0101_0000, 2'b00, 4'b0010, 1'b0));
        vecs.push_back(mk("j", 32'h0800_0010, 32'd3, 32'd4, 32'd7, 1'b0,
                          8'b0000_0001, 2'b00, 4'b0010, 1'b0));
        vecs.push_back(mk("bad_op", 32'hFC00_0000, 32'd1, 32'd2, 32'd3, 1'b0,
                          8'b0000_0000, 2'b00, 4'b0010, 1'b1));
        vecs.push_back(mk("bad_fn", 32'h0000_003F, 32'd1, 32'd2, 32'd0, 1'b1,
                          8'b1001_0000, 2'b10, 4'b1111, 1'b1));
`ifdef MIPS_EXEC_SHIFT_EN
        vecs.push_back(mk("srl", 32'h0000_00C2, 32'hFFFF, 32'h80, 32'h10, 1'b0,
                          8'b1001_0000, 2'b10, 4'b1001, 1'b0));
        vecs.push_back(mk("sll", 32'h0000_0100, 32'hFFFF, 32'd1, 32'h10, 1'b0,
                          8'b1001_0000, 2'b10, 4'b1000, 1'b0));
`else
        vecs.push_back(mk("srl_off", 32'h0000_00C2, 32'hFFFF, 32'h80, 32'd0, 1'b1,
                          8'b1001_0000, 2'b10, 4'b1111, 1'b1));
        vecs.push_back(mk("sll_off", 32'h0000_0100, 32'hFFFF, 32'd1, 32'd0, 1'b1,
                          8'b1001_0000, 2'b10, 4'b1111, 1'b1));
`endif

        rst = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].instr, vecs[k].rs, vecs[k].rt);
            check({vecs[k].name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
            check({vecs[k].name, ".result"}, result, vecs[k].res);
            check({vecs[k].name, ".zero"}, {31'd0, zero}, {31'd0, vecs[k].zero});
            check({vecs[k].name, ".ctl"}, {24'd0, ctl_now()}, {24'd0, vecs[k].ctl});
            check({vecs[k].name, ".alu_op"}, {30'd0, alu_op}, {30'd0, vecs[k].aop});
            check({vecs[k].name, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, vecs[k].actl});
            check({vecs[k].name, ".illegal"}, {31'd0, illegal}, {31'd0, vecs[k].ill});
        end

        // in_valid low: datapath still loads, out_valid drops
        drive(1'b0, 32'h0000_0020, 32'd20, 32'd22);
        check("novalid.out_valid", {31'd0, out_valid}, 32'd0);
        check("novalid.result", result, 32'd42);

        // Asynchronous reset between edges clears outputs without a clock edge
        drive(1'b1, 32'h0000_0020, 32'd7, 32'd5);
        check("pre_rst.result", result, 32'd12);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        #2;
        rst = 1'b1;
        in_valid = 1'b1; instr = 32'h0000_0020; rs_data = 32'd7; rt_data = 32'd5;
        @(posedge clk);
        #1;
        check("post_rst.out_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst.result", result, 32'd12);
        check("post_rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
